// File: rtl/home_access_pkg.sv
// -----------------------------------------------------------------------------
// home_access_pkg
// Shared constants for the door/garage keypad access arbiter:
//   PW_W                    - stored password width
//   OP_VERIFY / OP_CHANGE   - request opcode encoding (req_op bit per keypad)
//   ST_IDLE..ST_RESP        - arbiter FSM state encoding
//   DEFAULT_MAX_FAIL        - default consecutive failures before lockout
//   DEFAULT_LOCKOUT_CYCLES  - default lockout duration in clk cycles
// -----------------------------------------------------------------------------
package home_access_pkg;

    localparam int PW_W = 17;

    localparam logic OP_VERIFY = 1'b0;
    localparam logic OP_CHANGE = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int DEFAULT_MAX_FAIL       = 3;
    localparam int DEFAULT_LOCKOUT_CYCLES = 1000;

endpackage

// File: rtl/door_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// door_access_arbiter_if
// Bundles the keypad request/response signals of door_access_arbiter.
//   req_valid/req_op/req_password/req_new_password : keypads -> arbiter
//   req_ack/resp_valid/resp_ok/unlock              : arbiter -> keypads
//   locked_out/intrusion_alarm/busy                : arbiter status
// Modport master is the keypad side, slave is the arbiter side.
// -----------------------------------------------------------------------------
interface door_access_arbiter_if #(
    parameter int N    = 4,
    parameter int PW_W = home_access_pkg::PW_W
);
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_op;
    logic [N*PW_W-1:0] req_password;
    logic [N*PW_W-1:0] req_new_password;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      resp_valid;
    logic              resp_ok;
    logic [N-1:0]      unlock;
    logic [N-1:0]      locked_out;
    logic              intrusion_alarm;
    logic              busy;

    modport master (
        output req_valid, req_op, req_password, req_new_password,
        input  req_ack, resp_valid, resp_ok, unlock, locked_out,
               intrusion_alarm, busy
    );

    modport slave (
        input  req_valid, req_op, req_password, req_new_password,
        output req_ack, resp_valid, resp_ok, unlock, locked_out,
               intrusion_alarm, busy
    );
endinterface

// File: rtl/door_access_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req         in  N      request mask
//   ptr         in  IDX_W  index of the last winner (search starts at ptr+1)
//   grant       out N      one-hot winner
//   grant_idx   out IDX_W  binary index of the winner
//   grant_valid out 1      any request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk the requesters starting one past the previous winner; the first
    // hit wins, so the previous winner is always checked last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!grant_valid && req[(int'(ptr) + k) % N]) begin
                grant_valid                  = 1'b1;
                grant_idx                    = IDX_W'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/door_access_arbiter.sv
// -----------------------------------------------------------------------------
// door_access_arbiter
// One password store and comparator shared by N keypads (N-1 = garage).
// Requests are granted round-robin, checked against the requester's slot and
// answered with a one-cycle response. Repeated failures lock a keypad out for
// LOCKOUT_CYCLES and raise intrusion_alarm.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of door_access_arbiter_if (requests in, responses and
//          lockout/alarm/busy status out)
// -----------------------------------------------------------------------------
module door_access_arbiter
    import home_access_pkg::*;
#(
    parameter int              N              = 4,
    parameter int              PW_W           = home_access_pkg::PW_W,
    parameter int              MAX_FAIL       = DEFAULT_MAX_FAIL,
    parameter int              LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES,
    parameter logic [PW_W-1:0] DEFAULT_PW     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    door_access_arbiter_if.slave  bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [1:0]       state_q,    state_d;
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic [IDX_W-1:0] gidx_q,     gidx_d;
    logic [N-1:0]     gsel_q,     gsel_d;
    logic             op_q,       op_d;
    logic [PW_W-1:0]  pw_q,       pw_d;
    logic [PW_W-1:0]  new_pw_q,   new_pw_d;
    logic             match_q,    match_d;
    logic [N-1:0]     locked_q,   locked_d;
    logic [PW_W-1:0]  slot_q  [N];
    logic [PW_W-1:0]  slot_d  [N];
    logic [1:0]       fail_q  [N];
    logic [1:0]       fail_d  [N];
    logic [15:0]      timer_q [N];
    logic [15:0]      timer_d [N];
    logic [2:0]       fail_inc;

    logic [N-1:0]     eligible;
    logic [N-1:0]     arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    // Locked keypads stay pending on the bus but are invisible to arbitration.
    assign eligible = bus.req_valid & ~locked_q;

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (eligible),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        gsel_d   = gsel_q;
        op_d     = op_q;
        pw_d     = pw_q;
        new_pw_d = new_pw_q;
        match_d  = match_q;
        locked_d = locked_q;
        slot_d   = slot_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        fail_inc = '0;

        // Lockout timers run regardless of FSM state; the 1->0 step releases
        // the keypad so it can win arbitration on the following cycle.
        for (int i = 0; i < N; i++) begin
            if (timer_q[i] != 16'd0) begin
                timer_d[i] = timer_q[i] - 16'd1;
                if (timer_q[i] == 16'd1) begin
                    locked_d[i] = 1'b0;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gidx_d   = arb_idx;
                    gsel_d   = arb_grant;
                    ptr_d    = arb_idx;
                    op_d     = bus.req_op[arb_idx];
                    pw_d     = bus.req_password[int'(arb_idx)*PW_W +: PW_W];
                    new_pw_d = bus.req_new_password[int'(arb_idx)*PW_W +: PW_W];
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                match_d = (pw_q == slot_q[gidx_q]);
                state_d = (op_q == OP_CHANGE && match_d) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                slot_d[gidx_q] = new_pw_q;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                // A success wipes the failure history; the failure that
                // reaches MAX_FAIL locks the keypad and restarts its count.
                if (match_q) begin
                    fail_d[gidx_q] = 2'd0;
                end else begin
                    fail_inc = {1'b0, fail_q[gidx_q]} + 3'd1;
                    if (fail_inc == 3'(MAX_FAIL)) begin
                        locked_d[gidx_q] = 1'b1;
                        timer_d[gidx_q]  = 16'(LOCKOUT_CYCLES);
                        fail_d[gidx_q]   = 2'd0;
                    end else begin
                        fail_d[gidx_q] = fail_inc[1:0];
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer resets to N-1 so keypad 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(N - 1);
            gidx_q   <= '0;
            gsel_q   <= '0;
            op_q     <= OP_VERIFY;
            pw_q     <= '0;
            new_pw_q <= '0;
            match_q  <= 1'b0;
            locked_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i]  <= DEFAULT_PW;
                fail_q[i]  <= 2'd0;
                timer_q[i] <= 16'd0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            gsel_q   <= gsel_d;
            op_q     <= op_d;
            pw_q     <= pw_d;
            new_pw_q <= new_pw_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            slot_q   <= slot_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
        end
    end

    // Handshake pulses are decoded from the state, so they are naturally one
    // cycle wide and drop to zero the instant reset asserts.
    assign bus.req_ack         = (state_q == ST_CHECK) ? gsel_q : '0;
    assign bus.resp_valid      = (state_q == ST_RESP)  ? gsel_q : '0;
    assign bus.resp_ok         = (state_q == ST_RESP) && match_q;
    assign bus.unlock          = (state_q == ST_RESP && match_q && op_q == OP_VERIFY)
                                 ? gsel_q : '0;
    assign bus.locked_out      = locked_q;
    assign bus.intrusion_alarm = |locked_q;
    assign bus.busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_door_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_door_access_arbiter
// Directed bench for door_access_arbiter (N=4, LOCKOUT_CYCLES=20). Expected
// responses come from a password model and are queued when a request is
// driven; each response pulse seen on the bus is popped and compared.
// -----------------------------------------------------------------------------
module tb_door_access_arbiter;
    import home_access_pkg::*;

    localparam int N    = 4;
    localparam int PW   = 17;
    localparam int LOCK = 20;

    typedef struct {
        int   idx;
        logic ok;
        logic unl;
    } exp_t;

    logic          clk;
    logic          rst_n;
    exp_t          sb[$];
    logic [PW-1:0] model_slot [N];
    logic [N-1:0]  pending;
    int            compared;
    int            mismatched;
    int            ack_wait;

    door_access_arbiter_if #(.N(N), .PW_W(PW)) bus();

    door_access_arbiter #(
        .N              (N),
        .PW_W           (PW),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (LOCK),
        .DEFAULT_PW     ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge, drop acknowledged requests and
    // score any response pulse against the head of the expectation queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (pending[i] && bus.req_ack[i]) begin
                pending[i]       = 1'b0;
                bus.req_valid[i] = 1'b0;
            end
        end
        if (|bus.resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1 << e.idx);
                checkOutput("resp_ok", 32'(bus.resp_ok), 32'(e.ok));
                checkOutput("unlock", 32'(bus.unlock),
                            e.unl ? (32'd1 << e.idx) : 32'd0);
            end
        end else if (|bus.unlock) begin
            checkOutput("stray_unlock", 32'(bus.unlock), 32'd0);
        end
    endtask

    // Raise a keypad request; when tracked, the model decides the outcome.
    task automatic applyStimulus(input int idx, input logic op,
                                 input logic [PW-1:0] pw,
                                 input logic [PW-1:0] npw, input bit track);
        exp_t e;
        bus.req_op[idx]                     = op;
        bus.req_password[idx*PW +: PW]      = pw;
        bus.req_new_password[idx*PW +: PW]  = npw;
        bus.req_valid[idx]                  = 1'b1;
        pending[idx]                        = 1'b1;
        if (track) begin
            e.idx = idx;
            e.ok  = (pw == model_slot[idx]);
            e.unl = e.ok && (op == OP_VERIFY);
            if (op == OP_CHANGE && e.ok) model_slot[idx] = npw;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(pending == '0 && sb.size() == 0 && !bus.busy) && n < budget);
        if (!(pending == '0 && sb.size() == 0 && !bus.busy)) begin
            checkOutput("idle_timeout", 32'd1, 32'd0);
            pending       = '0;
            bus.req_valid = '0;
            sb.delete();
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        pending       = '0;
        rst_n         = 1'b0;
        tick();
        checkOutput("rst_req_ack",    32'(bus.req_ack), 32'd0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_ok",    32'(bus.resp_ok), 32'd0);
        checkOutput("rst_unlock",     32'(bus.unlock), 32'd0);
        checkOutput("rst_locked_out", 32'(bus.locked_out), 32'd0);
        checkOutput("rst_alarm",      32'(bus.intrusion_alarm), 32'd0);
        checkOutput("rst_busy",       32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) model_slot[i] = '0;
    endtask

    // Directed sequence covering latency, password change, round-robin
    // order, lockout/expiry, failure-count clearing and reset mid-write.
    initial begin
        compared             = 0;
        mismatched           = 0;
        rst_n                = 1'b0;
        pending              = '0;
        bus.req_valid        = '0;
        bus.req_op           = '0;
        bus.req_password     = '0;
        bus.req_new_password = '0;
        $display("[TB] start");

        do_reset();

        // Keypad 1 verify with default password: ack cycle 1, response cycle 2.
        applyStimulus(1, OP_VERIFY, 17'd0, 17'd0, 1'b1);
        tick();
        checkOutput("ack_cycle1", 32'(bus.req_ack), 32'b0010);
        tick();
        checkOutput("resp_cycle2", 32'(sb.size()), 32'd0);
        wait_idle(20);

        // Change keypad 1, then wrong and right verifies; slot 0 untouched.
        applyStimulus(1, OP_CHANGE, 17'd0, 17'd78954, 1'b1);
        wait_idle(20);
        applyStimulus(1, OP_VERIFY, 17'd45675, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(1, OP_VERIFY, 17'd78954, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(0, OP_VERIFY, 17'd0, 17'd0, 1'b1);
        wait_idle(20);

        // Simultaneous requests from reset, twice: expect order 0,1,3.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, OP_VERIFY, 17'd0, 17'd0, 1'b1);
            applyStimulus(1, OP_VERIFY, 17'd0, 17'd0, 1'b1);
            applyStimulus(3, OP_VERIFY, 17'd0, 17'd0, 1'b1);
            wait_idle(60);
        end

        // Garage: three wrong verifies lock it out and raise the alarm.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3, OP_VERIFY, 17'd5, 17'd0, 1'b1);
            wait_idle(20);
            if (k == 1) checkOutput("not_locked_yet", 32'(bus.locked_out), 32'd0);
        end
        checkOutput("garage_locked", 32'(bus.locked_out), 32'b1000);
        checkOutput("alarm_on", 32'(bus.intrusion_alarm), 32'd1);

        // A held request waits out the lockout before it is acknowledged.
        applyStimulus(3, OP_VERIFY, 17'd0, 17'd0, 1'b1);
        ack_wait = 0;
        while (pending[3] && ack_wait < 2 * LOCK) begin
            tick();
            ack_wait++;
            if (ack_wait == LOCK - 1)
                checkOutput("still_locked", 32'(bus.locked_out), 32'b1000);
            if (ack_wait == LOCK)
                checkOutput("lock_released", 32'(bus.locked_out), 32'd0);
        end
        checkOutput("ack_after_lockout", 32'(ack_wait), 32'(LOCK + 1));
        wait_idle(20);
        checkOutput("alarm_off", 32'(bus.intrusion_alarm), 32'd0);

        // Keypad 2: a success in the middle clears the failure count.
        applyStimulus(2, OP_VERIFY, 17'd9, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(2, OP_VERIFY, 17'd9, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(2, OP_VERIFY, 17'd0, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(2, OP_VERIFY, 17'd9, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(2, OP_VERIFY, 17'd9, 17'd0, 1'b1);
        wait_idle(20);
        checkOutput("no_lockout_k2", 32'(bus.locked_out), 32'd0);

        // Reset while a change is in WRITE: no response, slot back to default.
        applyStimulus(2, OP_CHANGE, 17'd0, 17'd12345, 1'b0);
        tick();
        checkOutput("chg_ack", 32'(bus.req_ack), 32'b0100);
        tick();
        checkOutput("in_write_busy", 32'(bus.busy), 32'd1);
        do_reset();
        tick();
        tick();
        applyStimulus(2, OP_VERIFY, 17'd0, 17'd0, 1'b1);
        wait_idle(20);
        applyStimulus(2, OP_VERIFY, 17'd12345, 17'd0, 1'b1);
        wait_idle(20);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
